// File: rtl/alu_scheduler.sv
// ---------------------------------------------------------------------------
// alu_scheduler
//
// Purpose:
//   Shares a single external combinational ALU between two requesters. Each
//   requester offers an operation (a, b, op) over a valid/ready handshake.
//   A round-robin arbiter picks one requester and latches its operands into
//   the registered ALU inputs. The ALU result is sampled one cycle later and
//   returned to that requester over a registered valid/ready response channel.
//   Only one operation is in flight at a time.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   reqN_valid/ready      request handshake for requester N (N = 0, 1)
//   reqN_a, reqN_b        operands for requester N
//   reqN_op               opcode for requester N
//   rspN_valid/ready      response handshake for requester N
//   rspN_c                registered result for requester N (holds last value)
//   rspN_err              illegal-opcode flag (only with ALU_ILLEGAL_OP_EN)
//   alu_a, alu_b, alu_op  registered operands/opcode driven to the ALU
//   alu_c                 combinational result returned by the ALU
//
// Configuration:
//   ALU_ILLEGAL_OP_EN  when defined, opcodes 110/111 are accepted but never
//                      reach the ALU: alu_op is driven 000, the result is
//                      forced to zero and rspN_err is raised. When undefined,
//                      every opcode is forwarded unchanged and there are no
//                      err ports.
// ---------------------------------------------------------------------------
module alu_scheduler #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 3
) (
  input  logic             clk,
  input  logic             reset,
  // requester 0
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OP_W-1:0]  req0_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_c,
  // requester 1
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OP_W-1:0]  req1_op,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_c,
`ifdef ALU_ILLEGAL_OP_EN
  output logic             rsp0_err,
  output logic             rsp1_err,
`endif
  // shared ALU
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_op,
  input  logic [WIDTH-1:0] alu_c
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state_q,      state_d;
  logic             owner_q,      owner_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] alu_a_q,      alu_a_d;
  logic [WIDTH-1:0] alu_b_q,      alu_b_d;
  logic [OP_W-1:0]  alu_op_q,     alu_op_d;
  logic             rsp0_valid_q, rsp0_valid_d;
  logic             rsp1_valid_q, rsp1_valid_d;
  logic [WIDTH-1:0] rsp0_c_q,     rsp0_c_d;
  logic [WIDTH-1:0] rsp1_c_q,     rsp1_c_d;
`ifdef ALU_ILLEGAL_OP_EN
  logic             illegal_q,    illegal_d;
  logic             rsp0_err_q,   rsp0_err_d;
  logic             rsp1_err_q,   rsp1_err_d;
  logic             sel_illegal;
`endif

  logic             grant0;
  logic             grant1;
  logic             accept0;
  logic             accept1;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [OP_W-1:0]  sel_op;
  logic [WIDTH-1:0] exec_result;
  logic             owner_rsp_ready;

  // Round-robin: a lone valid requester always wins; on a tie the requester
  // that was not granted last time wins. last_grant resets to 1 so that
  // requester 0 wins the very first tie.
  always_comb begin
    grant0 = req0_valid & (~req1_valid | last_grant_q);
    grant1 = req1_valid & (~req0_valid | ~last_grant_q);
  end

  // Ready is purely combinational from the current state and the grant, and
  // is masked by reset so nothing can be accepted while reset is asserted.
  always_comb begin
    req0_ready = (state_q == S_IDLE) & grant0 & ~reset;
    req1_ready = (state_q == S_IDLE) & grant1 & ~reset;
    accept0    = req0_valid & req0_ready;
    accept1    = req1_valid & req1_ready;
  end

  // Operand mux for whichever requester is being accepted this cycle.
  always_comb begin
    sel_a  = accept1 ? req1_a  : req0_a;
    sel_b  = accept1 ? req1_b  : req0_b;
    sel_op = accept1 ? req1_op : req0_op;
  end

  // Opcodes 110/111 are the two encodings with both top bits set.
`ifdef ALU_ILLEGAL_OP_EN
  always_comb begin
    sel_illegal = (sel_op[OP_W-1 -: 2] == 2'b11);
  end
`endif

  // Result captured at the end of EXEC; illegal ops never expose ALU output.
  always_comb begin
`ifdef ALU_ILLEGAL_OP_EN
    exec_result = illegal_q ? '0 : alu_c;
`else
    exec_result = alu_c;
`endif
  end

  always_comb begin
    owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;
  end

  // Next-state logic for the IDLE -> EXEC -> RESP -> IDLE sequence. Every
  // register holds its value unless a state explicitly updates it, which is
  // what keeps alu_* and rsp*_c stable after a transaction completes.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    rsp0_c_d     = rsp0_c_q;
    rsp1_c_d     = rsp1_c_q;
`ifdef ALU_ILLEGAL_OP_EN
    illegal_d    = illegal_q;
    rsp0_err_d   = rsp0_err_q;
    rsp1_err_d   = rsp1_err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (accept0 | accept1) begin
          alu_a_d      = sel_a;
          alu_b_d      = sel_b;
          owner_d      = accept1;
          last_grant_d = accept1;
          state_d      = S_EXEC;
`ifdef ALU_ILLEGAL_OP_EN
          illegal_d    = sel_illegal;
          alu_op_d     = sel_illegal ? '0 : sel_op;
`else
          alu_op_d     = sel_op;
`endif
        end
      end

      S_EXEC: begin
        state_d = S_RESP;
        if (owner_q) begin
          rsp1_valid_d = 1'b1;
          rsp1_c_d     = exec_result;
`ifdef ALU_ILLEGAL_OP_EN
          rsp1_err_d   = illegal_q;
`endif
        end else begin
          rsp0_valid_d = 1'b1;
          rsp0_c_d     = exec_result;
`ifdef ALU_ILLEGAL_OP_EN
          rsp0_err_d   = illegal_q;
`endif
        end
      end

      S_RESP: begin
        if (owner_rsp_ready) begin
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end

      default: begin
        state_d      = S_IDLE;
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
      end
    endcase
  end

  // Single register bank for the FSM and all of its registered outputs.
  // Asynchronous reset discards any in-flight transaction immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_c_q     <= '0;
      rsp1_c_q     <= '0;
`ifdef ALU_ILLEGAL_OP_EN
      illegal_q    <= 1'b0;
      rsp0_err_q   <= 1'b0;
      rsp1_err_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_c_q     <= rsp0_c_d;
      rsp1_c_q     <= rsp1_c_d;
`ifdef ALU_ILLEGAL_OP_EN
      illegal_q    <= illegal_d;
      rsp0_err_q   <= rsp0_err_d;
      rsp1_err_q   <= rsp1_err_d;
`endif
    end
  end

  always_comb begin
    alu_a      = alu_a_q;
    alu_b      = alu_b_q;
    alu_op     = alu_op_q;
    rsp0_valid = rsp0_valid_q;
    rsp1_valid = rsp1_valid_q;
    rsp0_c     = rsp0_c_q;
    rsp1_c     = rsp1_c_q;
`ifdef ALU_ILLEGAL_OP_EN
    rsp0_err   = rsp0_err_q;
    rsp1_err   = rsp1_err_q;
`endif
  end

endmodule

// File: tb/tb_alu_scheduler.sv
// ---------------------------------------------------------------------------
// tb_alu_scheduler
//
// Directed bench for alu_scheduler. Provides a behavioural ALU on the
// alu_* ports, drives both requesters, and scores every completed response
// against expected results queued when the corresponding request is driven.
// Opcodes 110/111 make the bench ALU return 32'hDEADBEEF so that forwarding
// of those opcodes is visible when ALU_ILLEGAL_OP_EN is undefined.
// ---------------------------------------------------------------------------
module tb_alu_scheduler;

  localparam int WIDTH = 32;
  localparam int OP_W  = 3;

  logic             clk;
  logic             reset;
  logic             req0_valid, req0_ready;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic [OP_W-1:0]  req0_op;
  logic             rsp0_valid, rsp0_ready;
  logic [WIDTH-1:0] rsp0_c;
  logic             req1_valid, req1_ready;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic [OP_W-1:0]  req1_op;
  logic             rsp1_valid, rsp1_ready;
  logic [WIDTH-1:0] rsp1_c;
`ifdef ALU_ILLEGAL_OP_EN
  logic             rsp0_err, rsp1_err;
`endif
  logic [WIDTH-1:0] alu_a, alu_b, alu_c;
  logic [OP_W-1:0]  alu_op;

  typedef struct {
    logic             owner;
    logic [WIDTH-1:0] c;
    logic             err;
  } exp_t;

  exp_t sb[$];
  int   checkCount = 0;
  int   errorCount = 0;

  alu_scheduler #(.WIDTH(WIDTH), .OP_W(OP_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_c     (rsp0_c),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_c     (rsp1_c),
`ifdef ALU_ILLEGAL_OP_EN
    .rsp0_err   (rsp0_err),
    .rsp1_err   (rsp1_err),
`endif
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_c      (alu_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; shifts use the full B value as the amount.
  always_comb begin
    case (alu_op)
      3'b000:  alu_c = alu_a + alu_b;
      3'b001:  alu_c = alu_a - alu_b;
      3'b010:  alu_c = alu_a & alu_b;
      3'b011:  alu_c = alu_a | alu_b;
      3'b100:  alu_c = alu_a >> alu_b;
      3'b101:  alu_c = $unsigned($signed(alu_a) >>> alu_b);
      default: alu_c = 32'hDEADBEEF;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) else begin
      errorCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pushExp(input logic owner, input logic [31:0] c, input logic err);
    exp_t e;
    e.owner = owner;
    e.c     = c;
    e.err   = err;
    sb.push_back(e);
  endtask

  task automatic score(input exp_t obs);
    exp_t e;
    checkOutput("rsp_expected", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checkOutput("rsp_owner", 32'(obs.owner), 32'(e.owner));
      checkOutput("rsp_c", obs.c, e.c);
`ifdef ALU_ILLEGAL_OP_EN
      checkOutput("rsp_err", 32'(obs.err), 32'(e.err));
`endif
    end
  endtask

  // Response monitor: a response completes on a valid & ready cycle.
  always @(negedge clk) begin
    exp_t o;
    if (!reset) begin
      checkOutput("rsp_exclusive", 32'(rsp0_valid & rsp1_valid), 32'd0);
      if (rsp0_valid && rsp0_ready) begin
        o.owner = 1'b0;
        o.c     = rsp0_c;
`ifdef ALU_ILLEGAL_OP_EN
        o.err   = rsp0_err;
`else
        o.err   = 1'b0;
`endif
        score(o);
      end
      if (rsp1_valid && rsp1_ready) begin
        o.owner = 1'b1;
        o.c     = rsp1_c;
`ifdef ALU_ILLEGAL_OP_EN
        o.err   = rsp1_err;
`else
        o.err   = 1'b0;
`endif
        score(o);
      end
    end
  end

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic n, input logic [31:0] a,
                               input logic [31:0] b, input logic [2:0] op);
    if (n) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end
  endtask

  // Wait (bounded) until every queued response has been scored, then one
  // more edge so the DUT is back in IDLE.
  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) cyc();
    checkOutput("drain_empty", sb.size(), 32'd0);
    cyc();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0; rsp0_ready = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0; rsp1_ready = 0;

    // Reset values, with a valid request present to show ready stays low.
    req0_valid = 1'b1;
    #3;
    checkOutput("rst_req0_ready", 32'(req0_ready), 32'd0);
    checkOutput("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    checkOutput("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    checkOutput("rst_rsp0_c", rsp0_c, 32'd0);
    checkOutput("rst_alu_a", alu_a, 32'd0);
    checkOutput("rst_alu_op", 32'(alu_op), 32'd0);
    cyc();
    req0_valid = 1'b0;
    reset = 1'b0;
    cyc();

    // Test 1: reset while a response is held, then requester 1 alone.
    applyStimulus(1'b0, 32'd1, 32'd2, 3'b000);
    rsp0_ready = 1'b0;
    #1 checkOutput("t1_req0_ready", 32'(req0_ready), 32'd1);
    cyc(); req0_valid = 1'b0;
    #1 checkOutput("t1_alu_a", alu_a, 32'd1);
    cyc();
    #1 checkOutput("t1_rsp0_valid", 32'(rsp0_valid), 32'd1);
    reset = 1'b1;
    req1_valid = 1'b1;
    #1 checkOutput("t1_rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    checkOutput("t1_rst_req1_ready", 32'(req1_ready), 32'd0);
    cyc();
    reset = 1'b0;
    applyStimulus(1'b1, 32'h0000000F, 32'h000000F0, 3'b011);
    rsp1_ready = 1'b1;
    #1 checkOutput("t1_req1_grant", 32'(req1_ready), 32'd1);
    pushExp(1'b1, 32'h000000FF, 1'b0);
    cyc(); req1_valid = 1'b0;
    drain();

    // Test 3: both valid continuously -> grants 0,1,0,1 every third cycle.
    applyStimulus(1'b0, 32'h10, 32'h4, 3'b001);
    applyStimulus(1'b1, 32'hF0, 32'h3C, 3'b010);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    pushExp(1'b0, 32'h0C, 1'b0);
    pushExp(1'b1, 32'h30, 1'b0);
    pushExp(1'b0, 32'h0C, 1'b0);
    pushExp(1'b1, 32'h30, 1'b0);
    for (int i = 0; i < 12; i++) begin
      #1;
      checkOutput($sformatf("t3_ready0_c%0d", i), 32'(req0_ready),
                  32'((i % 3 == 0) && ((i / 3) % 2 == 0)));
      checkOutput($sformatf("t3_ready1_c%0d", i), 32'(req1_ready),
                  32'((i % 3 == 0) && ((i / 3) % 2 == 1)));
      cyc();
      if (i == 9) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
    end
    drain();

    // Test 2: single add on requester 0.
    applyStimulus(1'b0, 32'd5, 32'd3, 3'b000);
    rsp0_ready = 1'b1;
    #1 checkOutput("t2_req0_ready", 32'(req0_ready), 32'd1);
    checkOutput("t2_req1_ready", 32'(req1_ready), 32'd0);
    pushExp(1'b0, 32'd8, 1'b0);
    cyc(); req0_valid = 1'b0;
    #1 checkOutput("t2_ready_one_cycle", 32'(req0_ready), 32'd0);
    checkOutput("t2_rsp0_exec", 32'(rsp0_valid), 32'd0);
    cyc();
    #1 checkOutput("t2_rsp0_valid", 32'(rsp0_valid), 32'd1);
    checkOutput("t2_rsp1_valid", 32'(rsp1_valid), 32'd0);
    cyc();
    #1 checkOutput("t2_rsp0_drop", 32'(rsp0_valid), 32'd0);
    checkOutput("t2_rsp0_c_hold", rsp0_c, 32'd8);
    drain();

    // Test 4/5: sra held by back-pressure, then full-B srl on requester 0.
    applyStimulus(1'b1, 32'h80000000, 32'd4, 3'b101);
    rsp1_ready = 1'b0;
    #1 checkOutput("t4_req1_ready", 32'(req1_ready), 32'd1);
    pushExp(1'b1, 32'hF8000000, 1'b0);
    cyc(); req1_valid = 1'b0;
    applyStimulus(1'b0, 32'hFFFFFFFF, 32'h20, 3'b100);
    rsp0_ready = 1'b1;
    #1 checkOutput("t4_req0_blocked_exec", 32'(req0_ready), 32'd0);
    cyc();
    for (int k = 0; k < 6; k++) begin
      #1;
      checkOutput($sformatf("t4_rsp1_valid_k%0d", k), 32'(rsp1_valid), 32'd1);
      checkOutput($sformatf("t4_rsp1_c_k%0d", k), rsp1_c, 32'hF8000000);
      checkOutput($sformatf("t4_req0_blocked_k%0d", k), 32'(req0_ready), 32'd0);
      cyc();
    end
    rsp1_ready = 1'b1;
    #1 checkOutput("t4_req0_blocked_hs", 32'(req0_ready), 32'd0);
    pushExp(1'b0, 32'h00000000, 1'b0);
    cyc();
    #1 checkOutput("t5_req0_ready", 32'(req0_ready), 32'd1);
    cyc(); req0_valid = 1'b0;
    drain();
    checkOutput("t5_alu_a_hold", alu_a, 32'hFFFFFFFF);
    checkOutput("t5_alu_b_hold", alu_b, 32'h20);
    checkOutput("t5_alu_op_hold", 32'(alu_op), 32'd4);

    // Test 6: opcode 110, then a legal add.
    applyStimulus(1'b0, 32'd1, 32'd1, 3'b110);
    rsp0_ready = 1'b1;
    #1 checkOutput("t6_req0_ready", 32'(req0_ready), 32'd1);
`ifdef ALU_ILLEGAL_OP_EN
    pushExp(1'b0, 32'd0, 1'b1);
`else
    pushExp(1'b0, 32'hDEADBEEF, 1'b0);
`endif
    cyc(); req0_valid = 1'b0;
`ifdef ALU_ILLEGAL_OP_EN
    #1 checkOutput("t6_alu_op", 32'(alu_op), 32'd0);
`else
    #1 checkOutput("t6_alu_op", 32'(alu_op), 32'd6);
`endif
    drain();
    applyStimulus(1'b0, 32'd1, 32'd1, 3'b000);
    pushExp(1'b0, 32'd2, 1'b0);
    cyc(); req0_valid = 1'b0;
    drain();

    checkOutput("final_sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
